// File: rtl/eth_tx_arb_if.sv
// rtl/eth_tx_arb_if.sv - requester/eth_tx signal bundle for eth_tx_arb (tx_abort_o only with ETH_TX_ARB_WDOG_EN)
interface eth_tx_arb_if #(
    parameter int REQ_N     = 4,
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int LEN_W     = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16
);
    localparam int GRANT_W = $clog2(REQ_N);

    logic [REQ_N-1:0]           req_valid_i;
    logic [REQ_N*DATA_W-1:0]    req_data_i;
    logic [REQ_N*LEN_W-1:0]     req_len_i;
    logic [REQ_N*PKT_LEN_W-1:0] req_pkt_len_i;
    logic [REQ_N*UDP_CS_W-1:0]  req_cs_i;
    logic [REQ_N-1:0]           req_ready_o;
    logic [REQ_N-1:0]           req_done_o;
    logic                       tx_ready_i;
    logic                       tx_valid_o;
    logic [DATA_W-1:0]          tx_data_o;
    logic [LEN_W-1:0]           tx_len_o;
    logic [PKT_LEN_W-1:0]       tx_pkt_len_o;
    logic [UDP_CS_W-1:0]        tx_cs_o;
    logic                       tx_start_o;
    logic                       tx_last_o;
    logic                       busy_o;
    logic [GRANT_W-1:0]         grant_o;
    logic                       err_len_o;
`ifdef ETH_TX_ARB_WDOG_EN
    logic                       tx_abort_o;
`endif

    modport master (
        output req_valid_i, req_data_i, req_len_i, req_pkt_len_i, req_cs_i, tx_ready_i,
        input  req_ready_o, req_done_o, tx_valid_o, tx_data_o, tx_len_o, tx_pkt_len_o,
               tx_cs_o, tx_start_o, tx_last_o, busy_o, grant_o, err_len_o
`ifdef ETH_TX_ARB_WDOG_EN
        , tx_abort_o
`endif
    );

    modport slave (
        input  req_valid_i, req_data_i, req_len_i, req_pkt_len_i, req_cs_i, tx_ready_i,
        output req_ready_o, req_done_o, tx_valid_o, tx_data_o, tx_len_o, tx_pkt_len_o,
               tx_cs_o, tx_start_o, tx_last_o, busy_o, grant_o, err_len_o
`ifdef ETH_TX_ARB_WDOG_EN
        , tx_abort_o
`endif
    );
endinterface

// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - packet-granular round-robin arbiter in front of eth_tx; ETH_TX_ARB_WDOG_EN adds stall abort
module eth_tx_arb #(
    parameter int REQ_N     = 4,
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int LEN_W     = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16,
    parameter int GAP_CYC   = 2
`ifdef ETH_TX_ARB_WDOG_EN
    , parameter int WDOG_CYC = 255
`endif
) (
    input  logic          clk,
    input  logic          nreset,
    eth_tx_arb_if.slave   bus
);
    localparam int GW  = $clog2(REQ_N);
    localparam int GCW = $clog2(GAP_CYC + 2);

    typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

    state_t               state;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        rr;
    logic [GW-1:0]        pick;
    logic [GW-1:0]        idx;
    logic [GW-1:0]        grant_inc;
    logic                 pick_found;
    logic [PKT_LEN_W-1:0] remaining;
    logic [PKT_LEN_W-1:0] pkt_len_q;
    logic [UDP_CS_W-1:0]  cs_q;
    logic                 first;
    logic [GCW-1:0]       gap_cnt;
    logic                 in_data;
    logic                 cur_valid;
    logic [LEN_W-1:0]     cur_len;
    logic [PKT_LEN_W-1:0] len_ext;
    logic                 last;
    logic                 accept;

    // Scan from the rr pointer downwards in reverse so the nearest valid requester wins.
    always_comb begin
        pick       = rr;
        idx        = rr;
        pick_found = 1'b0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            idx = GW'((int'(rr) + i) % REQ_N);
            if (bus.req_valid_i[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    assign grant_inc = (grant == GW'(REQ_N - 1)) ? '0 : grant + 1'b1;
    assign in_data   = (state == DATA);
    assign cur_valid = in_data & bus.req_valid_i[grant];
    assign cur_len   = bus.req_len_i[grant*LEN_W +: LEN_W];
    assign len_ext   = PKT_LEN_W'(cur_len);
    assign last      = (remaining <= len_ext);
    assign accept    = cur_valid & bus.tx_ready_i;

`ifdef ETH_TX_ARB_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);
    logic [WDW-1:0] wd_cnt;
    logic           abort;
    assign abort          = in_data & ~cur_valid & (wd_cnt == WDW'(WDOG_CYC - 1));
    assign bus.tx_abort_o = abort;
`endif

    assign bus.tx_valid_o   = cur_valid;
    assign bus.tx_data_o    = in_data ? bus.req_data_i[grant*DATA_W +: DATA_W] : '0;
    assign bus.tx_len_o     = !in_data ? '0 : (last ? remaining[LEN_W-1:0] : cur_len);
    assign bus.tx_start_o   = cur_valid & first;
    assign bus.tx_last_o    = cur_valid & last;
    assign bus.tx_pkt_len_o = pkt_len_q;
    assign bus.tx_cs_o      = cs_q;
    assign bus.busy_o       = (state != IDLE);
    assign bus.grant_o      = grant;
    // A zero remaining count only occurs when the announced length itself was zero.
    assign bus.err_len_o    = accept & ((remaining == '0) |
                              (last ? (len_ext > remaining) : (len_ext < PKT_LEN_W'(KEEP_W))));

    always_comb begin
        bus.req_ready_o = '0;
        bus.req_done_o  = '0;
        if (in_data) begin
            bus.req_ready_o[grant] = bus.tx_ready_i;
            bus.req_done_o[grant]  = accept & last;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            grant     <= '0;
            rr        <= '0;
            remaining <= '0;
            pkt_len_q <= '0;
            cs_q      <= '0;
            first     <= 1'b0;
            gap_cnt   <= '0;
`ifdef ETH_TX_ARB_WDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant     <= pick;
                        pkt_len_q <= bus.req_pkt_len_i[pick*PKT_LEN_W +: PKT_LEN_W];
                        cs_q      <= bus.req_cs_i[pick*UDP_CS_W +: UDP_CS_W];
                        remaining <= bus.req_pkt_len_i[pick*PKT_LEN_W +: PKT_LEN_W];
                        first     <= 1'b1;
                        state     <= DATA;
`ifdef ETH_TX_ARB_WDOG_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                DATA: begin
`ifdef ETH_TX_ARB_WDOG_EN
                    if (abort) begin
                        rr      <= grant_inc;
                        gap_cnt <= '0;
                        state   <= (GAP_CYC == 0) ? IDLE : GAP;
                    end else if (accept) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt != WDW'(WDOG_CYC - 1)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                    if (accept) begin
                        first <= 1'b0;
                        if (last) begin
                            remaining <= '0;
                            rr        <= grant_inc;
                            gap_cnt   <= '0;
                            state     <= (GAP_CYC == 0) ? IDLE : GAP;
                        end else begin
                            remaining <= remaining - len_ext;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GCW'(GAP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - self-checking bench for eth_tx_arb against a packet-level scoreboard
module tb_eth_tx_arb;
    localparam int REQ_N     = 4;
    localparam int DATA_W    = 16;
    localparam int KEEP_W    = 2;
    localparam int LEN_W     = 2;
    localparam int PKT_LEN_W = 16;
    localparam int UDP_CS_W  = 16;
    localparam int GAP_CYC   = 2;

    typedef struct {
        logic [15:0] data;
        int          len;
        int          pkt_len;
        int          cs;
    } beat_t;

    typedef struct {
        int          req;
        logic [15:0] data;
        int          len;
        bit          start;
        bit          last;
        bit          err;
        int          pkt_len;
        int          cs;
    } exp_t;

    typedef struct {
        int          pkt_len;
        int          cs;
        int          n;
        logic [63:0] lens;
    } pkt_t;

    logic clk;
    logic nreset;

    eth_tx_arb_if #(.REQ_N(REQ_N), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W),
                    .PKT_LEN_W(PKT_LEN_W), .UDP_CS_W(UDP_CS_W)) bus ();

    eth_tx_arb #(.REQ_N(REQ_N), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W),
                 .PKT_LEN_W(PKT_LEN_W), .UDP_CS_W(UDP_CS_W), .GAP_CYC(GAP_CYC))
        dut (.clk(clk), .nreset(nreset), .bus(bus));

    beat_t src_q[REQ_N][$];
    pkt_t  pend[REQ_N][$];
    exp_t  exp_q[$];
    int    start_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_err = 0;
    int model_rr = 0;
    int serial = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    int last_acc_cyc = 0;
    int prev_last_cyc = 0;
    bit have_prev = 0;
    bit turn_chk = 0;
    bit toggle_en = 0;

    task automatic chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [63:0] twos(int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[2*i +: 2] = 2'b10;
        return r;
    endfunction

    task automatic add_pkt(int k, int pkt_len, int cs, int n, logic [63:0] lens);
        pkt_t p;
        p.pkt_len = pkt_len; p.cs = cs; p.n = n; p.lens = lens;
        pend[k].push_back(p);
    endtask

    // Expected beats follow the length rules directly: clip at the announced length, flag short/overlong beats.
    task automatic emit(int k, pkt_t p);
        int    rem = p.pkt_len;
        bit    ended = 0;
        int    len;
        beat_t b;
        exp_t  e;
        for (int i = 0; i < p.n; i++) begin
            len = int'(p.lens[2*i +: 2]);
            b.data = 16'(k * 4096 + serial * 32 + i);
            b.len = len; b.pkt_len = p.pkt_len; b.cs = p.cs;
            src_q[k].push_back(b);
            if (!ended) begin
                e.req = k; e.data = b.data; e.start = (i == 0);
                e.last = (p.pkt_len == 0) || (rem <= len);
                e.len = e.last ? rem : len;
                e.err = (p.pkt_len == 0) || (e.last ? (len > rem) : (len < KEEP_W));
                e.pkt_len = p.pkt_len; e.cs = p.cs;
                exp_q.push_back(e);
                rem -= len;
                ended = e.last;
            end
        end
        serial++;
    endtask

    task automatic launch();
        bit found;
        int k;
        do begin
            found = 0;
            for (int o = 0; o < REQ_N; o++) begin
                k = (model_rr + o) % REQ_N;
                if (!found && pend[k].size() > 0) begin
                    found = 1;
                    emit(k, pend[k].pop_front());
                    model_rr = (k + 1) % REQ_N;
                end
            end
        end while (found);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic settle();
        repeat (GAP_CYC + 4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 nreset = 0;
        @(posedge clk);
        #2;
        for (int k = 0; k < REQ_N; k++) begin
            src_q[k].delete();
            pend[k].delete();
        end
        exp_q.delete();
        model_rr = 0;
        have_prev = 0;
        repeat (2) @(posedge clk);
        #2 nreset = 1;
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester sources and eth_tx ready; the only writer of DUT inputs.
    initial begin : drv
        logic [REQ_N-1:0] acc;
        logic [REQ_N-1:0] prev_v;
        bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_len_i = '0;
        bus.req_pkt_len_i = '0; bus.req_cs_i = '0; bus.tx_ready_i = 1'b1;
        prev_v = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_valid_i & bus.req_ready_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < REQ_N; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    bus.req_valid_i[k] = 1'b1;
                    bus.req_data_i[k*DATA_W +: DATA_W] = src_q[k][0].data;
                    bus.req_len_i[k*LEN_W +: LEN_W] = LEN_W'(src_q[k][0].len);
                    bus.req_pkt_len_i[k*PKT_LEN_W +: PKT_LEN_W] = PKT_LEN_W'(src_q[k][0].pkt_len);
                    bus.req_cs_i[k*UDP_CS_W +: UDP_CS_W] = UDP_CS_W'(src_q[k][0].cs);
                end else begin
                    bus.req_valid_i[k] = 1'b0;
                    bus.req_data_i[k*DATA_W +: DATA_W] = '0;
                    bus.req_len_i[k*LEN_W +: LEN_W] = '0;
                    bus.req_pkt_len_i[k*PKT_LEN_W +: PKT_LEN_W] = '0;
                    bus.req_cs_i[k*UDP_CS_W +: UDP_CS_W] = '0;
                end
            end
            if (bus.req_valid_i != '0 && prev_v == '0) rise_cyc = cyc;
            prev_v = bus.req_valid_i;
            bus.tx_ready_i = toggle_en ? ~bus.tx_ready_i : 1'b1;
        end
    end

    // Compare process: every accepted tx beat against the scoreboard, quiet flags otherwise.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (bus.tx_valid_o && bus.tx_ready_i) begin
                    n_acc++;
                    last_acc_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", bus.grant_o, e.req);
                        chk("data", bus.tx_data_o, e.data);
                        chk("len", bus.tx_len_o, e.len);
                        chk("start", bus.tx_start_o, e.start);
                        chk("last", bus.tx_last_o, e.last);
                        chk("err_len", bus.err_len_o, e.err);
                        chk("pkt_len", bus.tx_pkt_len_o, e.pkt_len);
                        chk("cs", bus.tx_cs_o, e.cs);
                        chk("ready", bus.req_ready_o, 1 << e.req);
                        chk("done", bus.req_done_o, e.last ? (1 << e.req) : 0);
                        if (e.start) begin
                            start_cyc = cyc;
                            start_log.push_back(e.req);
                            if (turn_chk && have_prev) chk("turnaround", cyc - prev_last_cyc, GAP_CYC + 2);
                        end
                        if (e.last) begin
                            prev_last_cyc = cyc;
                            have_prev = 1;
                        end
                    end
                end else begin
                    chk("idle_err", bus.err_len_o, 0);
                    chk("idle_done", bus.req_done_o, 0);
                end
                if (bus.err_len_o) n_err++;
            end
        end
    end

    initial begin
        int base;
        int eb;
        int n;
        int ord2[6];
        nreset = 0;
        repeat (3) @(posedge clk);
        #2 nreset = 1;

        @(negedge clk);
        chk("rst_tx_valid", bus.tx_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_pkt_len", bus.tx_pkt_len_o, 0);
        chk("rst_cs", bus.tx_cs_o, 0);
        chk("rst_start", bus.tx_start_o, 0);
        chk("rst_err", bus.err_len_o, 0);

        // Single 50-byte packet on requester 0
        base = n_acc;
        add_pkt(0, 50, 16'h1234, 25, twos(25));
        launch();
        wait_drain(200);
        chk("t1_beats", n_acc - base, 25);
        chk("t1_latency", start_cyc - rise_cyc, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy_o && n < 10);
        chk("t1_busy_low", cyc - last_acc_cyc, GAP_CYC + 1);
        settle();

        // Three requesters, two rounds of 4-byte packets
        do_reset();
        start_log.delete();
        turn_chk = 1;
        base = n_acc;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) add_pkt(k, 4, 16'hA000 + k, 2, twos(2));
        launch();
        wait_drain(300);
        chk("t2_beats", n_acc - base, 12);
        ord2 = '{0, 1, 2, 0, 1, 2};
        chk("t2_npkts", start_log.size(), 6);
        for (int i = 0; i < 6 && i < start_log.size(); i++) chk("t2_order", start_log[i], ord2[i]);
        settle();

        // Length violations: clipped last beat, zero length, short middle beat
        have_prev = 0;
        eb = n_err;
        add_pkt(1, 5, 16'h00C5, 3, 64'h2A);
        add_pkt(2, 0, 16'h00C0, 1, 64'h2);
        add_pkt(3, 6, 16'h00C6, 4, 64'h69);
        launch();
        wait_drain(300);
        chk("t3_err_pulses", n_err - eb, 3);
        turn_chk = 0;
        settle();

        // Backpressure toggling every cycle
        toggle_en = 1;
        base = n_acc;
        add_pkt(0, 8, 16'h0088, 4, twos(4));
        launch();
        wait_drain(200);
        chk("t4_accepts", n_acc - base, 4);
        toggle_en = 0;
        settle();

        // Reset in the middle of a long packet
        base = n_acc;
        add_pkt(0, 50, 16'h5050, 25, twos(25));
        launch();
        n = 0;
        while (n_acc - base < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reached_beat3", (n_acc - base) >= 3, 1);
        @(negedge clk);
        #2 nreset = 0;
        #1;
        chk("t5_rst_valid", bus.tx_valid_o, 0);
        chk("t5_rst_busy", bus.busy_o, 0);
        chk("t5_rst_ready", bus.req_ready_o, 0);
        chk("t5_rst_grant", bus.grant_o, 0);
        chk("t5_rst_pkt_len", bus.tx_pkt_len_o, 0);
        @(posedge clk);
        #2;
        for (int k = 0; k < REQ_N; k++) begin
            src_q[k].delete();
            pend[k].delete();
        end
        exp_q.delete();
        model_rr = 0;
        have_prev = 0;
        repeat (2) @(posedge clk);
        #2 nreset = 1;
        start_log.delete();
        add_pkt(1, 4, 16'h0011, 2, twos(2));
        add_pkt(0, 4, 16'h0010, 2, twos(2));
        launch();
        wait_drain(200);
        chk("t5_npkts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            chk("t5_first", start_log[0], 0);
            chk("t5_second", start_log[1], 1);
        end
        settle();

        // rr pointer wrap from requester 3 back to 0
        add_pkt(3, 2, 16'h0033, 1, twos(1));
        launch();
        wait_drain(100);
        settle();
        start_log.delete();
        add_pkt(1, 4, 16'h0021, 2, twos(2));
        add_pkt(0, 4, 16'h0020, 2, twos(2));
        launch();
        wait_drain(200);
        chk("t6_npkts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            chk("t6_first", start_log[0], 0);
            chk("t6_second", start_log[1], 1);
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1);
    end
endmodule
